// File: rtl/dvp_raw_pattern_tx_pkg.sv
// Shared types and helpers for the synthetic RAW8 DVP pattern transmitter:
// frame FSM states, pattern codes and the RGGB colour-bar lookup.
package dvp_raw_pattern_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } tx_state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  localparam int NUM_BARS = 8;

  // {R,G,B} on/off mask per bar, left to right: W,Y,C,G,M,R,B,K
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // RGGB mosaic: even row/even col is R, odd row/odd col is B, the rest G
  function automatic logic [7:0] bayer_pick(input logic [2:0] rgb, input logic y0, input logic x0);
    logic on;
    case ({y0, x0})
      2'b00:   on = rgb[2];
      2'b11:   on = rgb[0];
      default: on = rgb[1];
    endcase
    return on ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Registered RAW8 sample generator: turns pixel coordinates and the frame's
// latched pattern selection into one Bayer sample, forced to zero outside href.
module dvp_pattern_gen
  import dvp_raw_pattern_tx_pkg::*;
#(
  parameter int X_W       = 12,
  parameter int Y_W       = 11,
  parameter int CHK_SHIFT = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid,
  input  logic [1:0]     pattern,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [2:0]     bar_idx,
  input  logic [7:0]     const_val,
  output logic [7:0]     data
);

  logic [7:0] sample;

  always_comb begin
    sample = 8'h00;
    case (pattern)
      PAT_BARS:  sample = bayer_pick(bar_rgb(bar_idx), y[0], x[0]);
      PAT_RAMP:  sample = 8'(x) + 8'(y);
      PAT_CHECK: sample = (x[CHK_SHIFT] ^ y[CHK_SHIFT]) ? 8'hFF : 8'h00;
      default:   sample = const_val;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= 8'h00;
    end else begin
      data <= valid ? sample : 8'h00;
    end
  end

endmodule

// File: rtl/dvp_raw_pattern_tx.sv
// OV5640-style RAW8 DVP transmitter: line timer, frame FSM and frame counter
// driving registered vsync/href/data from the dvp_pattern_gen sample source.
module dvp_raw_pattern_tx
  import dvp_raw_pattern_tx_pkg::*;
#(
  parameter int H_PIXELS  = 1920,
  parameter int V_PIXELS  = 1080,
  parameter int H_BLANK   = 280,
  parameter int VSYNC_LEN = 4,
  parameter int V_BP      = 16,
  parameter int V_FP      = 4,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CHK_SHIFT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  const_val,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_PIXELS + H_BLANK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int L_MAX_A = (VSYNC_LEN > V_BP) ? VSYNC_LEN : V_BP;
  localparam int L_MAX_B = (V_PIXELS > V_FP) ? V_PIXELS : V_FP;
  localparam int L_MAX   = (L_MAX_A > L_MAX_B) ? L_MAX_A : L_MAX_B;
  localparam int LINE_W  = $clog2(L_MAX + 1);
  localparam int BAR_W   = H_PIXELS / NUM_BARS;

  tx_state_e         state, state_next;
  logic [H_W-1:0]    h_cnt;
  logic [H_W-1:0]    bar_cnt;
  logic [2:0]        bar_idx;
  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] line_last_idx;
  logic [1:0]        pat_q;
  logic [7:0]        const_q;
  logic              h_wrap;
  logic              line_end;
  logic              frame_end;
  logic              active_px;

  assign h_wrap    = (h_cnt == H_W'(H_TOTAL - 1));
  assign line_end  = h_wrap && (line_cnt == line_last_idx);
  assign frame_end = line_end && ((state == ST_VFP) || ((state == ST_ACTIVE) && (V_FP == 0)));
  assign active_px = (state == ST_ACTIVE) && (h_cnt < H_W'(H_PIXELS));

  always_comb begin
    line_last_idx = '0;
    case (state)
      ST_VSYNC:  line_last_idx = LINE_W'(VSYNC_LEN - 1);
      ST_VBP:    line_last_idx = LINE_W'((V_BP > 0) ? V_BP - 1 : 0);
      ST_ACTIVE: line_last_idx = LINE_W'(V_PIXELS - 1);
      ST_VFP:    line_last_idx = LINE_W'((V_FP > 0) ? V_FP - 1 : 0);
      default:   line_last_idx = '0;
    endcase
  end

  // Zero-length porches are skipped; the enable check happens only at frame end
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (enable) state_next = ST_VSYNC;
      ST_VSYNC:  if (line_end) state_next = (V_BP > 0) ? ST_VBP : ST_ACTIVE;
      ST_VBP:    if (line_end) state_next = ST_ACTIVE;
      ST_ACTIVE: if (line_end) state_next = (V_FP > 0) ? ST_VFP : (enable ? ST_VSYNC : ST_IDLE);
      ST_VFP:    if (line_end) state_next = enable ? ST_VSYNC : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      bar_cnt  <= '0;
      bar_idx  <= '0;
      line_cnt <= '0;
      pat_q    <= PAT_BARS;
      const_q  <= 8'h00;
    end else begin
      if ((state == ST_IDLE) || h_wrap) begin
        h_cnt   <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + H_W'(1);
        // Bar index steps every BAR_W pixels and sticks on the last bar
        if (bar_idx != 3'(NUM_BARS - 1)) begin
          if (bar_cnt == H_W'(BAR_W - 1)) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + H_W'(1);
          end
        end
      end

      if (state_next != state) begin
        line_cnt <= '0;
      end else if (h_wrap) begin
        line_cnt <= line_cnt + LINE_W'(1);
      end

      if ((state_next == ST_VSYNC) && (state != ST_VSYNC)) begin
        pat_q   <= pattern_sel;
        const_q <= const_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvp_vsync  <= ~VSYNC_POL;
      dvp_href   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      dvp_vsync  <= (state == ST_VSYNC) ? VSYNC_POL : ~VSYNC_POL;
      dvp_href   <= active_px;
      frame_done <= frame_end;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  dvp_pattern_gen #(
    .X_W       (H_W),
    .Y_W       (LINE_W),
    .CHK_SHIFT (CHK_SHIFT)
  ) u_pattern_gen (
    .clk       (clk),
    .reset     (reset),
    .valid     (active_px),
    .pattern   (pat_q),
    .x         (h_cnt),
    .y         (line_cnt),
    .bar_idx   (bar_idx),
    .const_val (const_q),
    .data      (dvp_data)
  );

endmodule
